// File: rtl/ram_line_responder.sv
// Main-memory responder for cache refills: 4-word line reads and single-word
// write-through stores, with a programmable wait before the first array access.
module ram_line_responder #(
    parameter int    ADDR_W    = 15,
    parameter int    LATENCY   = 4,
    parameter string INIT_FILE = ""
) (
    input  logic              globalclock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [127:0]      resp_line,
    output logic              wr_done,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] LAT_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_BEAT,
        S_WRITE,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [1:0]        beat_q, beat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [127:0]      line_q, line_d;
    logic              wr_done_q, wr_done_d;

    logic [31:0]       mem [0:DEPTH-1];
    logic [ADDR_W-1:0] rd_addr_d;
    logic [31:0]       rdata_q;
    logic              mem_we;
    logic [ADDR_W-1:0] line_base;

    assign line_base = {addr_q[ADDR_W-1:2], 2'b00};

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        beat_d     = beat_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        line_d     = line_q;
        wr_done_d  = 1'b0;
        mem_we     = 1'b0;
        rd_addr_d  = line_base;

        case (state_q)
            S_IDLE: begin
                // Prefetch word 0 so it is already registered when BEAT starts at LATENCY 0.
                rd_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                if (req_valid) begin
                    addr_d     = req_addr;
                    wr_d       = req_wr;
                    wdata_d    = req_wdata;
                    wait_cnt_d = 4'd0;
                    beat_d     = 2'd0;
                    if (LATENCY > 0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = req_wr ? S_WRITE : S_BEAT;
                    end
                end
            end

            S_WAIT: begin
                rd_addr_d  = line_base;
                wait_cnt_d = wait_cnt_q + 4'd1;
                if (wait_cnt_q == LAT_LAST) begin
                    wait_cnt_d = 4'd0;
                    state_d    = wr_q ? S_WRITE : S_BEAT;
                end
            end

            S_BEAT: begin
                // Next word is fetched while the current one is stored; the fetch after
                // beat 3 is never consumed, so its wrap at the top of memory is harmless.
                rd_addr_d = line_base + ADDR_W'(beat_q) + ADDR_W'(1);
                case (beat_q)
                    2'd0:    line_d[127:96] = rdata_q;
                    2'd1:    line_d[95:64]  = rdata_q;
                    2'd2:    line_d[63:32]  = rdata_q;
                    default: line_d[31:0]   = rdata_q;
                endcase
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    beat_d  = 2'd0;
                    state_d = S_RESP;
                end
            end

            S_WRITE: begin
                mem_we    = 1'b1;
                wr_done_d = 1'b1;
                state_d   = S_IDLE;
            end

            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge globalclock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
            beat_q     <= 2'd0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= 32'd0;
            line_q     <= 128'd0;
            wr_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            beat_q     <= beat_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            line_q     <= line_d;
            wr_done_q  <= wr_done_d;
        end
    end

    // Array has no reset; an abandoned write never reaches S_WRITE, so mem_we stays low.
    always_ff @(posedge globalclock) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
        rdata_q <= mem[rd_addr_d];
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_line  = line_q;
    assign wr_done    = wr_done_q;

endmodule
